cook_timer_countdown: RTL

//  Microwave cook timer. Consumes the divided time-base level from the clock divider and counts a
//  BCD MM:SS value down to 00:00. Start/pause/clear/door control; drives magnetron enable,
//  a done flag and a timed alarm. Sits between keypad/control logic and the display and alarm stages.

---
 rtl/cook_timer_countdown.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cook_timer_countdown.sv
// Microwave cook timer: counts a BCD MM:SS value down to 00:00 on a divided time base,
// with start/pause/clear/door control, magnetron enable, done flag and timed alarm.
module cook_timer_countdown #(
  parameter int TICKS_PER_SEC = 1,
  parameter int ALARM_SECS    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       load,
  input  logic [3:0] ld_mt,
  input  logic [3:0] ld_mu,
  input  logic [3:0] ld_st,
  input  logic [3:0] ld_su,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       door_open,
  output logic [3:0] mt,
  output logic [3:0] mu,
  output logic [3:0] st,
  output logic [3:0] su,
  output logic       running,
  output logic       mag_en,
  output logic       done,
  output logic       alarm,
  output logic       load_err
);

  typedef enum logic [2:0] {IDLE, SET, RUN, PAUSED, DONE} state_t;

  localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_SEC - 1);
  localparam logic [3:0] ALARM_LAST = 4'(ALARM_SECS - 1);

  state_t     state, state_nx;
  logic [3:0] mt_nx, mu_nx, st_nx, su_nx;
  logic [3:0] dec_mt, dec_mu, dec_st, dec_su;
  logic [3:0] alarm_cnt, alarm_cnt_nx;
  logic [7:0] presc, presc_nx;
  logic       tick_prev, tk, sec_pulse;
  logic       alarm_nx, load_err_nx, start_ok;
  logic       load_ok, load_nonzero, dec_zero;

  assign tk           = tick_in & ~tick_prev;
  assign sec_pulse    = tk && (presc == PRESC_LAST);
  assign load_ok      = (ld_mt <= 4'd9) && (ld_mu <= 4'd9) && (ld_st <= 4'd5) && (ld_su <= 4'd9);
  assign load_nonzero = |{ld_mt, ld_mu, ld_st, ld_su};
  assign running      = (state == RUN);
  assign done         = (state == DONE);

  // One-second BCD decrement with borrow ripple su -> st -> mu -> mt.
  always_comb begin
    dec_mt = mt;
    dec_mu = mu;
    dec_st = st;
    dec_su = su;
    if (su != 4'd0) begin
      dec_su = su - 4'd1;
    end else begin
      dec_su = 4'd9;
      if (st != 4'd0) begin
        dec_st = st - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (mu != 4'd0) begin
          dec_mu = mu - 4'd1;
        end else begin
          dec_mu = 4'd9;
          dec_mt = mt - 4'd1;
        end
      end
    end
  end

  assign dec_zero = ({dec_mt, dec_mu, dec_st, dec_su} == 16'h0000);

  // Each branch fires only when it takes effect; pause always consumes the edge.
  always_comb begin
    state_nx     = state;
    mt_nx        = mt;
    mu_nx        = mu;
    st_nx        = st;
    su_nx        = su;
    alarm_nx     = alarm;
    alarm_cnt_nx = alarm_cnt;
    load_err_nx  = 1'b0;
    start_ok     = 1'b0;
    presc_nx     = presc;

    if (clear) begin
      state_nx = IDLE;
      mt_nx    = 4'd0;
      mu_nx    = 4'd0;
      st_nx    = 4'd0;
      su_nx    = 4'd0;
      alarm_nx = 1'b0;
    end else if (door_open && state == RUN) begin
      state_nx = PAUSED;
    end else if (pause) begin
      if (state == RUN) state_nx = PAUSED;
    end else if (load && state != RUN) begin
      if (load_ok) begin
        mt_nx    = ld_mt;
        mu_nx    = ld_mu;
        st_nx    = ld_st;
        su_nx    = ld_su;
        state_nx = load_nonzero ? SET : IDLE;
        alarm_nx = 1'b0;
      end else begin
        load_err_nx = 1'b1;
      end
    end else if (start && (state == SET || state == PAUSED)) begin
      if (!door_open) begin
        state_nx = RUN;
        start_ok = 1'b1;
      end
    end else if (sec_pulse && state == RUN) begin
      mt_nx = dec_mt;
      mu_nx = dec_mu;
      st_nx = dec_st;
      su_nx = dec_su;
      if (dec_zero) begin
        state_nx     = DONE;
        alarm_nx     = 1'b1;
        alarm_cnt_nx = 4'd0;
      end
    end

    if (state == DONE && state_nx == DONE && sec_pulse && alarm) begin
      alarm_cnt_nx = alarm_cnt + 4'd1;
      if (alarm_cnt == ALARM_LAST) alarm_nx = 1'b0;
    end

    // Restarting the prescaler makes the first decrement a full second after start.
    if (start_ok || state_nx == IDLE) begin
      presc_nx = 8'd0;
    end else if (tk) begin
      presc_nx = sec_pulse ? 8'd0 : presc + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mt        <= 4'd0;
      mu        <= 4'd0;
      st        <= 4'd0;
      su        <= 4'd0;
      tick_prev <= tick_in;
      presc     <= 8'd0;
      alarm     <= 1'b0;
      alarm_cnt <= 4'd0;
      mag_en    <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      mt        <= mt_nx;
      mu        <= mu_nx;
      st        <= st_nx;
      su        <= su_nx;
      tick_prev <= tick_in;
      presc     <= presc_nx;
      alarm     <= alarm_nx;
      alarm_cnt <= alarm_cnt_nx;
      mag_en    <= (state_nx == RUN) && !door_open;
      load_err  <= load_err_nx;
    end
  end

endmodule
